ika2151_noise_ctrl: RTL and testbench



---
 rtl/ika2151_noise_pkg.sv | 14 +
 rtl/ika2151_noise_ctrl_if.sv | 12 +
 rtl/ika2151_noise_regif.sv | 95 +++++++++
 rtl/ika2151_noise_ctrl.sv | 106 ++++++++++
 tb/tb_ika2151_noise_ctrl.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ika2151_noise_pkg.sv
// Shared constants and configuration type for the noise generator front-end.
package ika2151_noise_pkg;

  localparam logic [7:0] NOISE_REG_ADDR = 8'h0F;
  localparam logic [4:0] CYC_12         = 5'd12;
  localparam logic [4:0] CYC_15         = 5'd15;
  localparam logic [4:0] CYC_31         = 5'd31;

  typedef struct packed {
    logic       ne;
    logic [4:0] nfrq;
  } noise_cfg_t;

endpackage

// File: rtl/ika2151_noise_ctrl_if.sv
// Host write bus of the noise front-end: address/data strobes, data byte and busy flag.
interface ika2151_noise_ctrl_if;

  logic       i_ADDR_WR;
  logic       i_DATA_WR;
  logic [7:0] i_DIN;
  logic       o_BUSY;

  modport master (output i_ADDR_WR, output i_DATA_WR, output i_DIN, input o_BUSY);
  modport slave  (input i_ADDR_WR, input i_DATA_WR, input i_DIN, output o_BUSY);

endinterface

// File: rtl/ika2151_noise_regif.sv
// Host register interface: address latch, 0x0F decode, busy counter and (with
// IKA2151_NFRQ_FRAME_SYNC_EN) the shadow/pending configuration copy.
module ika2151_noise_regif
  import ika2151_noise_pkg::*;
#(
  parameter int BUSY_LEN = 32
) (
`ifdef IKA2151_NFRQ_FRAME_SYNC_EN
  input  logic       apply_i,
  output noise_cfg_t shadow_o,
  output logic       pending_o,
`else
  output logic       cfg_wr_o,
  output noise_cfg_t cfg_wr_val_o,
`endif
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       ncen_i,
  ika2151_noise_ctrl_if.slave bus
);

  localparam logic [5:0] BUSY_INIT = 6'(BUSY_LEN);

  logic [7:0] addr_q, addr_d;
  logic [5:0] busy_cnt_q, busy_cnt_d;
  logic       busy_q, busy_d;
  logic       data_wr, cfg_hit;
  noise_cfg_t wr_val;

  // A simultaneous address strobe swallows the data strobe entirely.
  assign data_wr = bus.i_DATA_WR && !bus.i_ADDR_WR;
  assign cfg_hit = data_wr && (addr_q == NOISE_REG_ADDR);
  assign wr_val  = '{ne: bus.i_DIN[7], nfrq: bus.i_DIN[4:0]};

  always_comb begin
    addr_d     = addr_q;
    busy_cnt_d = busy_cnt_q;
    busy_d     = busy_q;
    if (bus.i_ADDR_WR) addr_d = bus.i_DIN;
    if (data_wr) begin
      busy_cnt_d = BUSY_INIT;
      busy_d     = 1'b1;
    end else if (ncen_i && busy_cnt_q != 6'd0) begin
      busy_cnt_d = busy_cnt_q - 6'd1;
      busy_d     = (busy_cnt_q != 6'd1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      addr_q     <= 8'h00;
      busy_cnt_q <= 6'd0;
      busy_q     <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      busy_cnt_q <= busy_cnt_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.o_BUSY = busy_q;

`ifdef IKA2151_NFRQ_FRAME_SYNC_EN
  noise_cfg_t shadow_q, shadow_d;
  logic       pending_q, pending_d;

  // A write landing on the apply edge overrides the clear and keeps pending set.
  always_comb begin
    shadow_d  = shadow_q;
    pending_d = pending_q;
    if (apply_i) pending_d = 1'b0;
    if (cfg_hit) begin
      shadow_d  = wr_val;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      shadow_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
    end
  end

  assign shadow_o  = shadow_q;
  assign pending_o = pending_q;
`else
  assign cfg_wr_o     = cfg_hit;
  assign cfg_wr_val_o = wr_val;
`endif

endmodule

// File: rtl/ika2151_noise_ctrl.sv
// Noise sequencer: 32-slot phi1 cycle counter, timing strobes, NE/NFRQ apply and
// slot-31 noise select. Macro IKA2151_NFRQ_FRAME_SYNC_EN defers NE/NFRQ to the 31->0 wrap.
module ika2151_noise_ctrl
  import ika2151_noise_pkg::*;
#(
  parameter int BUSY_LEN   = 32,
  parameter int NOISE_SLOT = 31
) (
  input  logic       i_EMUCLK,
  input  logic       i_MRST_n,
  input  logic       i_phi1_PCEN_n,
  input  logic       i_phi1_NCEN_n,
  ika2151_noise_ctrl_if.slave bus,
  output logic [4:0] o_CYCLE,
  output logic       o_CYCLE_12,
  output logic       o_CYCLE_15_31,
  output logic [4:0] o_NFRQ,
  output logic       o_NE,
  output logic       o_NOISE_SEL
);

  localparam logic [4:0] SEL_SLOT = 5'(NOISE_SLOT);

  logic       ncen;
  logic [4:0] cyc_q, cyc_d;
  logic       c12_q, c12_d, c1531_q, c1531_d;
  noise_cfg_t active_q, active_d;
  // Everything in this block moves on the negative phi1 enable only.
  logic       unused_pcen_n;

  assign ncen          = !i_phi1_NCEN_n;
  assign unused_pcen_n = i_phi1_PCEN_n;

`ifdef IKA2151_NFRQ_FRAME_SYNC_EN
  noise_cfg_t shadow;
  logic       pending, apply;

  assign apply = ncen && (cyc_q == CYC_31) && pending;

  ika2151_noise_regif #(.BUSY_LEN(BUSY_LEN)) u_regif (
    .apply_i   (apply),
    .shadow_o  (shadow),
    .pending_o (pending),
    .clk_i     (i_EMUCLK),
    .rst_n_i   (i_MRST_n),
    .ncen_i    (ncen),
    .bus       (bus)
  );

  always_comb begin
    active_d = active_q;
    if (apply) active_d = shadow;
  end
`else
  logic       cfg_wr;
  noise_cfg_t cfg_wr_val;

  ika2151_noise_regif #(.BUSY_LEN(BUSY_LEN)) u_regif (
    .cfg_wr_o     (cfg_wr),
    .cfg_wr_val_o (cfg_wr_val),
    .clk_i        (i_EMUCLK),
    .rst_n_i      (i_MRST_n),
    .ncen_i       (ncen),
    .bus          (bus)
  );

  always_comb begin
    active_d = active_q;
    if (cfg_wr) active_d = cfg_wr_val;
  end
`endif

  // Strobes decode the next count so they change together with o_CYCLE.
  always_comb begin
    cyc_d   = cyc_q;
    c12_d   = c12_q;
    c1531_d = c1531_q;
    if (ncen) begin
      cyc_d   = cyc_q + 5'd1;
      c12_d   = (cyc_d == CYC_12);
      c1531_d = (cyc_d == CYC_15) || (cyc_d == CYC_31);
    end
  end

  always_ff @(posedge i_EMUCLK) begin
    if (!i_MRST_n) begin
      cyc_q    <= 5'd0;
      c12_q    <= 1'b0;
      c1531_q  <= 1'b0;
      active_q <= '0;
    end else begin
      cyc_q    <= cyc_d;
      c12_q    <= c12_d;
      c1531_q  <= c1531_d;
      active_q <= active_d;
    end
  end

  assign o_CYCLE       = cyc_q;
  assign o_CYCLE_12    = c12_q;
  assign o_CYCLE_15_31 = c1531_q;
  assign o_NE          = active_q.ne;
  assign o_NFRQ        = active_q.nfrq;
  assign o_NOISE_SEL   = (cyc_q == SEL_SLOT) && active_q.ne;

endmodule

// File: tb/tb_ika2151_noise_ctrl.sv
// Self-checking bench for ika2151_noise_ctrl against a behavioural frame/busy model.
module tb_ika2151_noise_ctrl;

  localparam int BUSY_LEN = 32;

  logic       clk = 1'b0;
  logic       mrst_n, pcen_n, ncen_n;
  logic [4:0] cycle, nfrq;
  logic       c12, c1531, ne, sel;

  always #5 clk = ~clk;

  ika2151_noise_ctrl_if bus();

  ika2151_noise_ctrl #(.BUSY_LEN(BUSY_LEN), .NOISE_SLOT(31)) dut (
    .i_EMUCLK      (clk),
    .i_MRST_n      (mrst_n),
    .i_phi1_PCEN_n (pcen_n),
    .i_phi1_NCEN_n (ncen_n),
    .bus           (bus.slave),
    .o_CYCLE       (cycle),
    .o_CYCLE_12    (c12),
    .o_CYCLE_15_31 (c1531),
    .o_NFRQ        (nfrq),
    .o_NE          (ne),
    .o_NOISE_SEL   (sel)
  );

  int checks = 0;
  int failures = 0;

  // Reference model state
  int       m_cyc, m_busy_left;
  bit [7:0] m_addr;
  bit       m_sh_ne, m_pend, m_ne;
  bit [4:0] m_sh_nfrq, m_nfrq;

  logic [14:0] dut_vec;
  assign dut_vec = {cycle, c12, c1531, nfrq, ne, sel, bus.o_BUSY};

  function automatic logic [14:0] model_vec();
    logic [4:0] c;
    c = 5'(m_cyc);
    return {c, 1'(m_cyc == 12), 1'(m_cyc == 15 || m_cyc == 31), m_nfrq, m_ne,
            1'(m_cyc == 31 && m_ne), 1'(m_busy_left > 0)};
  endfunction

  task automatic tick(input bit rst_n, input bit a, input bit d, input bit [7:0] din, input bit n);
    bit wrap;
    mrst_n        = rst_n;
    bus.i_ADDR_WR = a;
    bus.i_DATA_WR = d;
    bus.i_DIN     = din;
    ncen_n        = ~n;
    pcen_n        = 1'($urandom_range(0, 1));
    @(posedge clk);
    if (!rst_n) begin
      m_cyc = 0; m_busy_left = 0; m_addr = 8'h00;
      m_sh_ne = 0; m_sh_nfrq = 0; m_pend = 0; m_ne = 0; m_nfrq = 0;
    end else begin
      wrap = n && (m_cyc == 31);
`ifdef IKA2151_NFRQ_FRAME_SYNC_EN
      if (wrap && m_pend) begin
        m_ne = m_sh_ne; m_nfrq = m_sh_nfrq; m_pend = 0;
      end
`endif
      if (a) m_addr = din;
      else if (d) begin
        m_busy_left = BUSY_LEN;
        if (m_addr == 8'h0F) begin
          m_sh_ne = din[7]; m_sh_nfrq = din[4:0]; m_pend = 1;
`ifndef IKA2151_NFRQ_FRAME_SYNC_EN
          m_ne = din[7]; m_nfrq = din[4:0];
`endif
        end
      end
      if (n && !(d && !a) && m_busy_left > 0) m_busy_left--;
      if (n) m_cyc = (m_cyc + 1) % 32;
    end
    #1;
    mrst_n = 1'b1; bus.i_ADDR_WR = 1'b0; bus.i_DATA_WR = 1'b0; ncen_n = 1'b1;
  endtask

  task automatic test_reset();
    tick(1, 1, 0, 8'h0F, 1);
    tick(1, 0, 1, 8'hFF, 1);
    tick(0, 0, 0, 8'h00, 1);
    checks++;
    if (dut_vec !== 15'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=%h", dut_vec, 15'd0);
    end
  endtask

  task automatic test_counter();
    int n12 = 0, n1531 = 0, nsel = 0;
    tick(0, 0, 0, 8'h00, 0);
    for (int i = 0; i < 64; i++) begin
      if ($urandom_range(0, 2) == 0) tick(1, 0, 0, 8'h00, 0);
      tick(1, 0, 0, 8'h00, 1);
      checks++;
      if (cycle !== 5'((i + 1) % 32)) begin
        failures++;
        $display("FAIL counter_walk step=%0d got=%0d want=%0d", i, cycle, (i + 1) % 32);
      end
      checks++;
      if (c12 !== (((i + 1) % 32) == 12) || c1531 !== (((i + 1) % 32) == 15 || ((i + 1) % 32) == 31)) begin
        failures++;
        $display("FAIL strobe_decode step=%0d got=%b%b", i, c12, c1531);
      end
      n12 += int'(c12); n1531 += int'(c1531); nsel += int'(sel);
    end
    checks++;
    if (n12 != 2 || n1531 != 4 || nsel != 0) begin
      failures++;
      $display("FAIL strobe_counts got=%0d/%0d/%0d want=2/4/0", n12, n1531, nsel);
    end
  endtask

  task automatic test_noise_write();
    int nsel = 0;
    tick(0, 0, 0, 8'h00, 0);
    for (int i = 0; i < 5; i++) tick(1, 0, 0, 8'h00, 1);
    tick(1, 1, 0, 8'h0F, 0);
    tick(1, 0, 1, 8'h9A, 0);
`ifdef IKA2151_NFRQ_FRAME_SYNC_EN
    checks++;
    if ({ne, nfrq} !== 6'h00) begin
      failures++;
      $display("FAIL cfg_held_after_write got=%h want=00", {ne, nfrq});
    end
    for (int i = 0; i < 40 && cycle !== 5'd31; i++) tick(1, 0, 0, 8'h00, 1);
    checks++;
    if (cycle !== 5'd31 || {ne, nfrq} !== 6'h00) begin
      failures++;
      $display("FAIL cfg_held_at_31 got=%0d/%h want=31/00", cycle, {ne, nfrq});
    end
    tick(1, 0, 0, 8'h00, 1);
`endif
    checks++;
    if (ne !== 1'b1 || nfrq !== 5'h1A) begin
      failures++;
      $display("FAIL cfg_applied got=%b/%h want=1/1a", ne, nfrq);
    end
    for (int i = 0; i < 40; i++) begin
      tick(1, 0, 0, 8'h00, 1);
      nsel += int'(sel);
      checks++;
      if (dut_vec !== model_vec()) begin
        failures++;
        $display("FAIL noise_frame step=%0d got=%h want=%h", i, dut_vec, model_vec());
      end
    end
    checks++;
    if (nsel != 1) begin
      failures++;
      $display("FAIL noise_sel_pulses got=%0d want=1", nsel);
    end
  endtask

  task automatic test_other_addr();
    logic [5:0] cfg_before;
    int high = 0;
    cfg_before = {ne, nfrq};
    tick(1, 1, 0, 8'h10, 0);
    tick(1, 0, 1, 8'hFF, 0);
    for (int i = 0; i < 200 && bus.o_BUSY === 1'b1; i++) begin
      tick(1, 0, 0, 8'h00, 1);
      high++;
    end
    checks++;
    if (high != BUSY_LEN) begin
      failures++;
      $display("FAIL busy_len got=%0d want=%0d", high, BUSY_LEN);
    end
    checks++;
    if ({ne, nfrq} !== cfg_before) begin
      failures++;
      $display("FAIL other_addr_cfg got=%h want=%h", {ne, nfrq}, cfg_before);
    end
  endtask

  task automatic test_back_to_back();
    int high = 0;
    logic [5:0] cfg_before;
    tick(1, 1, 0, 8'h22, 0);
    cfg_before = {ne, nfrq};
    tick(1, 1, 1, 8'h0F, 0);
    checks++;
    if ({ne, nfrq} !== cfg_before) begin
      failures++;
      $display("FAIL collision_cfg got=%h want=%h", {ne, nfrq}, cfg_before);
    end
    for (int i = 0; i < 80; i++) tick(1, 0, 0, 8'h00, 1);
    tick(1, 0, 1, 8'h85, 0);
    for (int i = 0; i < 10; i++) begin
      tick(1, 0, 0, 8'h00, 1);
      high += int'(bus.o_BUSY === 1'b1);
    end
    tick(1, 0, 1, 8'h85, 0);
    for (int i = 0; i < 200 && bus.o_BUSY === 1'b1; i++) begin
      tick(1, 0, 0, 8'h00, 1);
      high++;
    end
    checks++;
    if (high != 42) begin
      failures++;
      $display("FAIL busy_reload got=%0d want=42", high);
    end
    for (int i = 0; i < 32; i++) tick(1, 0, 0, 8'h00, 1);
    checks++;
    if (ne !== 1'b1 || nfrq !== 5'h05) begin
      failures++;
      $display("FAIL latch_from_collision got=%b/%h want=1/05", ne, nfrq);
    end
  endtask

  task automatic test_reset_mid();
    tick(0, 0, 0, 8'h00, 0);
    for (int i = 0; i < 3; i++) tick(1, 0, 0, 8'h00, 1);
    tick(1, 1, 0, 8'h0F, 0);
    tick(1, 0, 1, 8'h8C, 0);
    while (cycle !== 5'd20 && m_cyc < 20) tick(1, 0, 0, 8'h00, 1);
    tick(0, 0, 0, 8'h00, 1);
    checks++;
    if (dut_vec !== 15'd0) begin
      failures++;
      $display("FAIL reset_mid got=%h want=%h", dut_vec, 15'd0);
    end
    tick(1, 0, 0, 8'h00, 1);
    checks++;
    if (cycle !== 5'd1) begin
      failures++;
      $display("FAIL resume_count got=%0d want=1", cycle);
    end
    for (int i = 0; i < 40; i++) tick(1, 0, 0, 8'h00, 1);
    checks++;
    if ({ne, nfrq} !== 6'h00) begin
      failures++;
      $display("FAIL pending_lost got=%h want=00", {ne, nfrq});
    end
  endtask

  task automatic test_random();
    bit a, d, n, r;
    bit [7:0] din;
    for (int i = 0; i < 2000; i++) begin
      a   = ($urandom_range(0, 7) == 0);
      d   = ($urandom_range(0, 5) == 0);
      n   = ($urandom_range(0, 2) == 0);
      r   = ($urandom_range(0, 299) != 0);
      din = (a && $urandom_range(0, 1) == 1) ? 8'h0F : 8'($urandom);
      tick(r, a, d, din, n);
      checks++;
      if (dut_vec !== model_vec()) begin
        failures++;
        $display("FAIL random step=%0d got=%h want=%h", i, dut_vec, model_vec());
      end
    end
  endtask

  initial begin
    mrst_n = 1'b0; pcen_n = 1'b1; ncen_n = 1'b1;
    bus.i_ADDR_WR = 1'b0; bus.i_DATA_WR = 1'b0; bus.i_DIN = 8'h00;
    test_reset();
    test_counter();
    test_noise_write();
    test_other_addr();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
